// File: rtl/ecc_scalar_mul_ctrl.sv
// Left-to-right double-and-add-always controller for Q = k*P over GF(p).
// Issues one double and one keep-flagged add per scalar bit below the MSB.
module ecc_scalar_mul_ctrl #(
  parameter int WIDTH = 256
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_k,
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  input  logic [WIDTH-1:0] i_p,
  output logic             o_op_start,
  output logic             o_op_dbl,
  output logic             o_op_add,
  output logic [WIDTH-1:0] o_op_x1,
  output logic [WIDTH-1:0] o_op_y1,
  output logic [WIDTH-1:0] o_op_x2,
  output logic [WIDTH-1:0] o_op_y2,
  output logic [WIDTH-1:0] o_op_p,
  input  logic             i_op_finish,
  input  logic [WIDTH-1:0] i_op_x,
  input  logic [WIDTH-1:0] i_op_y,
  output logic             o_busy,
  output logic             o_finished,
  output logic [WIDTH-1:0] o_result_x,
  output logic [WIDTH-1:0] o_result_y
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // state | meaning: IDLE wait start | SCAN find MSB | DBL/ADD issue op | *_WAIT await op | DONE publish Q
  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_DBL, S_DBL_WAIT, S_ADD, S_ADD_WAIT, S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_k, r_px, r_py, r_rx, r_ry;
  logic [CW-1:0]    r_cnt;
  logic             r_op_start, r_op_dbl, r_op_add;
  logic [WIDTH-1:0] r_op_x1, r_op_y1, r_op_x2, r_op_y2;
  logic             r_finished;
  logic [WIDTH-1:0] r_res_x, r_res_y;

  logic             w_accept, w_trivial, w_bit, w_cnt_zero;
  logic [WIDTH-1:0] w_rx_nxt, w_ry_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_issue_dbl, w_issue_add, w_finished_nxt;

  assign w_accept   = (r_state == S_IDLE) && i_start;
  assign w_trivial  = (i_k == '0) || ((&i_x) && (&i_y));
  assign w_bit      = r_k[r_cnt];
  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (i_start) w_state_nxt = w_trivial ? S_DONE : S_SCAN;
      S_SCAN:     if (w_bit) w_state_nxt = w_cnt_zero ? S_DONE : S_DBL;
      S_DBL:      w_state_nxt = S_DBL_WAIT;
      S_DBL_WAIT: if (i_op_finish) w_state_nxt = S_ADD;
      S_ADD:      w_state_nxt = S_ADD_WAIT;
      S_ADD_WAIT: if (i_op_finish) w_state_nxt = w_cnt_zero ? S_DONE : S_DBL;
      S_DONE:     w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_rx_nxt       = r_rx;
    w_ry_nxt       = r_ry;
    w_cnt_nxt      = r_cnt;
    w_finished_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_cnt_nxt = CW'(WIDTH - 1);
          if (w_trivial) begin
            w_rx_nxt = '1;
            w_ry_nxt = '1;
          end
        end
      end
      S_SCAN: begin
        if (w_bit) begin
          w_rx_nxt = r_px;
          w_ry_nxt = r_py;
        end
        if (!(w_bit && w_cnt_zero)) w_cnt_nxt = r_cnt - 1'b1;
      end
      S_DBL_WAIT: begin
        if (i_op_finish) begin
          w_rx_nxt = i_op_x;
          w_ry_nxt = i_op_y;
        end
      end
      S_ADD_WAIT: begin
        if (i_op_finish) begin
          w_rx_nxt = i_op_x;
          w_ry_nxt = i_op_y;
          if (!w_cnt_zero) w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_DONE:  w_finished_nxt = 1'b1;
      default: ;
    endcase
    w_issue_dbl = (w_state_nxt == S_DBL);
    w_issue_add = (w_state_nxt == S_ADD);
  end

  // Operand registers load on entry to DBL/ADD and hold through the op's finish cycle.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_k        <= '0;
      r_px       <= '0;
      r_py       <= '0;
      r_rx       <= '0;
      r_ry       <= '0;
      r_cnt      <= '0;
      r_op_start <= 1'b0;
      r_op_dbl   <= 1'b0;
      r_op_add   <= 1'b0;
      r_op_x1    <= '0;
      r_op_y1    <= '0;
      r_op_x2    <= '0;
      r_op_y2    <= '0;
      r_finished <= 1'b0;
      r_res_x    <= '0;
      r_res_y    <= '0;
    end else begin
      if (w_accept) begin
        r_k  <= i_k;
        r_px <= i_x;
        r_py <= i_y;
      end
      r_rx       <= w_rx_nxt;
      r_ry       <= w_ry_nxt;
      r_cnt      <= w_cnt_nxt;
      r_op_start <= w_issue_dbl || w_issue_add;
      if (w_issue_dbl) begin
        r_op_dbl <= 1'b1;
        r_op_add <= 1'b0;
        r_op_x1  <= w_rx_nxt;
        r_op_y1  <= w_ry_nxt;
        r_op_x2  <= w_rx_nxt;
        r_op_y2  <= w_ry_nxt;
      end else if (w_issue_add) begin
        r_op_dbl <= 1'b0;
        r_op_add <= w_bit;
        r_op_x1  <= w_rx_nxt;
        r_op_y1  <= w_ry_nxt;
        r_op_x2  <= r_px;
        r_op_y2  <= r_py;
      end
      r_finished <= w_finished_nxt;
      if (w_finished_nxt) begin
        r_res_x <= r_rx;
        r_res_y <= r_ry;
      end
    end
  end

  assign o_op_start = r_op_start;
  assign o_op_dbl   = r_op_dbl;
  assign o_op_add   = r_op_add;
  assign o_op_x1    = r_op_x1;
  assign o_op_y1    = r_op_y1;
  assign o_op_x2    = r_op_x2;
  assign o_op_y2    = r_op_y2;
  assign o_op_p     = i_p;
  assign o_busy     = (r_state != S_IDLE);
  assign o_finished = r_finished;
  assign o_result_x = r_res_x;
  assign o_result_y = r_res_y;

endmodule

// File: tb/tb_ecc_scalar_mul_ctrl.sv
// Bench for ecc_scalar_mul_ctrl: a curve-arithmetic op unit on y^2 = x^3 + 2x + 2 mod 17
// answers requests; expectations come from naive repeated point addition.
module tb_ecc_scalar_mul_ctrl;
  localparam int W = 8;
  localparam int PRIME = 17;
  localparam logic [W-1:0] INF = 8'hFF;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b0;
  logic         i_start = 1'b0;
  logic [W-1:0] i_k = '0, i_x = '0, i_y = '0, i_p = 8'd17;
  logic         i_op_finish = 1'b0;
  logic [W-1:0] i_op_x = '0, i_op_y = '0;
  logic         o_op_start, o_op_dbl, o_op_add, o_busy, o_finished;
  logic [W-1:0] o_op_x1, o_op_y1, o_op_x2, o_op_y2, o_op_p, o_result_x, o_result_y;

  int errors = 0;
  int checks = 0;

  ecc_scalar_mul_ctrl #(.WIDTH(W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
    .i_k(i_k), .i_x(i_x), .i_y(i_y), .i_p(i_p),
    .o_op_start(o_op_start), .o_op_dbl(o_op_dbl), .o_op_add(o_op_add),
    .o_op_x1(o_op_x1), .o_op_y1(o_op_y1), .o_op_x2(o_op_x2), .o_op_y2(o_op_y2),
    .o_op_p(o_op_p), .i_op_finish(i_op_finish), .i_op_x(i_op_x), .i_op_y(i_op_y),
    .o_busy(o_busy), .o_finished(o_finished),
    .o_result_x(o_result_x), .o_result_y(o_result_y)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int md(input int v);
    int r;
    r = v % PRIME;
    return (r < 0) ? r + PRIME : r;
  endfunction

  function automatic int inv(input int a);
    for (int i = 1; i < PRIME; i++) if (md(a * i) == 1) return i;
    return 0;
  endfunction

  function automatic logic [15:0] ec_add(input logic [7:0] x1, input logic [7:0] y1,
                                         input logic [7:0] x2, input logic [7:0] y2);
    int a1, b1, a2, b2, lam, x3, y3;
    if (x1 == INF && y1 == INF) return {x2, y2};
    if (x2 == INF && y2 == INF) return {x1, y1};
    a1 = int'(x1); b1 = int'(y1); a2 = int'(x2); b2 = int'(y2);
    if (a1 == a2) begin
      if (md(b1 + b2) == 0) return {INF, INF};
      lam = md(md(3 * a1 * a1 + 2) * inv(md(2 * b1)));
    end else begin
      lam = md(md(b2 - b1) * inv(md(a2 - a1)));
    end
    x3 = md(lam * lam - a1 - a2);
    y3 = md(lam * (a1 - x3) - b1);
    return {x3[7:0], y3[7:0]};
  endfunction

  function automatic logic [15:0] smul(input int m, input logic [7:0] bx, input logic [7:0] by);
    logic [15:0] r;
    r = {INF, INF};
    for (int i = 0; i < m; i++) r = ec_add(r[15:8], r[7:0], bx, by);
    return r;
  endfunction

  task automatic run_mul(input logic [7:0] k, input logic [7:0] px, input logic [7:0] py,
                         input int lat, input bit inj_start, input bit inj_fin, input string tag);
    bit          trivial, done, active, stable;
    int          msb, n_exp, cyc, nops, cd, mm, bi;
    logic [15:0] exp_q, er, res;
    logic [33:0] cap, act, eop;
    trivial = (k == 8'd0) || (px == INF && py == INF);
    msb = 0;
    for (int i = 0; i < W; i++) if (k[i]) msb = i;
    exp_q = trivial ? {INF, INF} : smul(int'(k), px, py);
    n_exp = trivial ? 2 : (W - msb) + 2 * msb * (lat + 1) + 2;
    done = 1'b0; active = 1'b0; stable = 1'b1;
    cyc = 1; nops = 0; cd = 0; cap = '0; res = '0;
    @(negedge i_clk);
    i_k = k; i_x = px; i_y = py; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    chk($sformatf("%s_busy", tag), 64'(o_busy), 64'd1);
    while (!done && cyc <= n_exp + 8) begin
      i_op_finish = 1'b0;
      i_start = 1'b0;
      if (inj_start && cyc == 3) begin
        i_start = 1'b1; i_k = ~k; i_x = 8'h11; i_y = 8'h22;
      end
      act = {o_op_dbl, o_op_add, o_op_x1, o_op_y1, o_op_x2, o_op_y2};
      if (active) begin
        if (act !== cap) stable = 1'b0;
        cd--;
        if (cd == 0) begin
          i_op_finish = 1'b1;
          {i_op_x, i_op_y} = res;
          active = 1'b0;
        end
      end
      if (o_op_start) begin
        if (nops < 2 * msb) begin
          mm = int'(k >> (msb - nops / 2));
          bi = msb - 1 - nops / 2;
          if (nops % 2 == 0) begin
            er  = smul(mm, px, py);
            eop = {1'b1, 1'b0, er, er};
          end else begin
            er  = smul(2 * mm, px, py);
            eop = {1'b0, k[bi], er, px, py};
          end
          chk($sformatf("%s_op%0d", tag, nops), 64'(act), 64'(eop));
        end
        cap = act;
        if (o_op_dbl)      res = ec_add(o_op_x1, o_op_y1, o_op_x1, o_op_y1);
        else if (o_op_add) res = ec_add(o_op_x1, o_op_y1, o_op_x2, o_op_y2);
        else               res = {o_op_x1, o_op_y1};
        cd = lat; active = 1'b1; nops++;
        if (inj_fin && !o_op_dbl) begin
          i_op_finish = 1'b1; i_op_x = 8'hA5; i_op_y = 8'h5A;
        end
      end
      if (o_finished) begin
        done = 1'b1;
        chk($sformatf("%s_latency", tag), 64'(cyc), 64'(n_exp));
        chk($sformatf("%s_result", tag), 64'({o_result_x, o_result_y}), 64'(exp_q));
        chk($sformatf("%s_idle_at_done", tag), 64'(o_busy), 64'd0);
      end else begin
        @(negedge i_clk);
        cyc++;
      end
    end
    if (!done) chk($sformatf("%s_timeout", tag), 64'd0, 64'd1);
    chk($sformatf("%s_opcount", tag), 64'(nops), 64'(trivial ? 0 : 2 * msb));
    chk($sformatf("%s_stable", tag), 64'(stable), 64'd1);
    @(negedge i_clk);
    i_op_finish = 1'b0;
    i_start = 1'b0;
    chk($sformatf("%s_hold", tag), 64'({o_finished, o_result_x, o_result_y}), 64'({1'b0, exp_q}));
  endtask

  initial begin
    bit          seen;
    logic [7:0]  rk;
    logic [15:0] bp;
    int          j;

    @(negedge i_clk);
    chk("reset_outputs", 64'({o_op_start, o_op_dbl, o_op_add, o_op_x1, o_op_y1, o_op_x2,
                              o_op_y2, o_busy, o_finished, o_result_x, o_result_y}), 64'd0);
    chk("op_p_passthru", 64'(o_op_p), 64'(i_p));
    i_rst = 1'b1;

    run_mul(8'd0, 8'd5, 8'd1, 1, 1'b0, 1'b0, "k0");
    run_mul(8'd1, 8'd5, 8'd1, 2, 1'b0, 1'b0, "k1");
    run_mul(8'd5, 8'd5, 8'd1, 3, 1'b0, 1'b0, "k5");
    run_mul(8'd2, 8'd5, 8'd1, 1, 1'b0, 1'b0, "k2");
    chk("k2_known_point", 64'({o_result_x, o_result_y}), 64'h0603);
    run_mul(8'd7, INF, INF, 2, 1'b0, 1'b0, "infP");
    run_mul(8'd13, 8'd5, 8'd1, 2, 1'b1, 1'b1, "inject");

    // Abort a run while the first double is outstanding.
    @(negedge i_clk);
    i_k = 8'd3; i_x = 8'd5; i_y = 8'd1; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    for (int c = 0; c < 40 && !(o_op_start && o_op_dbl); c++) @(negedge i_clk);
    chk("rst_reach_dbl", 64'(o_op_start && o_op_dbl), 64'd1);
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    chk("rst_abort_outputs", 64'({o_op_start, o_op_dbl, o_op_add, o_op_x1, o_op_y1, o_op_x2,
                                  o_op_y2, o_busy, o_finished, o_result_x, o_result_y}), 64'd0);
    @(negedge i_clk);
    i_rst = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge i_clk);
      if (o_finished || o_busy) seen = 1'b1;
    end
    chk("rst_no_finish", 64'(seen), 64'd0);
    run_mul(8'd1, 8'd6, 8'd3, 1, 1'b0, 1'b0, "post_rst");

    for (int n = 0; n < 12; n++) begin
      rk = 8'($urandom_range(0, 255));
      j  = int'($urandom_range(1, 18));
      bp = smul(j, 8'd5, 8'd1);
      run_mul(rk, bp[15:8], bp[7:0], int'($urandom_range(1, 4)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ecc_scalar_mul_ctrl.md
# ecc_scalar_mul_ctrl

Scalar-multiplication controller that computes Q = k·P over GF(p) using left-to-right double-and-add-always. It sits directly upstream of the point-operation units: it sequences one doubling and one add request per scalar bit, and drives the add request's keep flag (`o_op_add`) with the scalar bit. An add is therefore always performed, and its result is kept only when the bit is 1. The point at infinity is encoded as x = y = all-ones throughout.

## Interface
- `WIDTH`, 256, operand width; equals `MAX_BITS` from ECCDefine.vh.
- `i_clk`  in  1  clock; all flops on rising edge.
- `i_rst`  in  1  asynchronous, active-low reset.
- `i_start`  in  1  one-cycle start pulse; sampled only in IDLE.
- `i_k`  in  WIDTH  scalar.
- `i_x`, `i_y`  in  WIDTH  base point P.
- `i_p`  in  WIDTH  field prime; passed through combinationally to `o_op_p`.
- `o_op_start`  out  1  one-cycle request pulse to the point-op unit.
- `o_op_dbl`  out  1  request type: 1 = double R, 0 = add R + P.
- `o_op_add`  out  1  keep flag for add requests (current scalar bit); 0 during doubles.
- `o_op_x1`, `o_op_y1`, `o_op_x2`, `o_op_y2`  out  WIDTH  operands: (R, R) for a double, (R, P) for an add.
- `o_op_p`  out  WIDTH  field prime.
- `i_op_finish`  in  1  one-cycle completion pulse from the op unit.
- `i_op_x`, `i_op_y`  in  WIDTH  op result; valid only while `i_op_finish` is high.
- `o_busy`  out  1  high whenever state ≠ IDLE.
- `o_finished`  out  1  one-cycle done pulse.
- `o_result_x`, `o_result_y`  out  WIDTH  Q; held until the next accepted start.

## Operation
- On an accepted start, latch `i_k`, `i_x`, `i_y` into k_r, Px, Py and set the bit counter cnt = WIDTH-1.
- The op unit reads its operands in every cycle of an operation. `o_op_*` operands and flags are registered and must stay stable from the `o_op_start` cycle through the `i_op_finish` cycle.
- States: IDLE, SCAN, DBL, DBL_WAIT, ADD, ADD_WAIT, DONE.
- IDLE, on `i_start`:
  - If `i_k` == 0, or `i_x` and `i_y` are both all-ones: result = infinity, go to DONE.
  - Otherwise go to SCAN.
- SCAN examines k_r[cnt], one bit per cycle:
  - Bit 0: cnt--.
  - Bit 1: R = P. Then go to DONE if cnt == 0; otherwise cnt--, go to DBL.
- DBL: assert `o_op_start` with `o_op_dbl`=1 and operands (R, R), then go to DBL_WAIT.
- DBL_WAIT: on `i_op_finish`, R = (`i_op_x`, `i_op_y`), go to ADD.
- ADD: assert `o_op_start` with `o_op_dbl`=0, `o_op_add`=k_r[cnt] and operands (R, P), then go to ADD_WAIT.
- ADD_WAIT: on `i_op_finish`, R = op result (the unit returns R itself when add=0). Then go to DONE if cnt == 0; otherwise cnt--, go to DBL.
- DONE: result = R, pulse `o_finished`, return to IDLE.
- The controller never special-cases an intermediate infinity or an x-collision; it passes through whatever the op unit returns, including the all-ones encoding.
- `i_start` outside IDLE is ignored.
- `i_op_finish` outside the WAIT states is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, cnt 0, R 0. Asserting `i_rst` mid-operation aborts immediately; no `o_finished` is issued.
- Start sampled at edge E0 → `o_busy` high from E0.
- SCAN costs one cycle per bit examined, MSB inclusive: WIDTH−msb cycles.
- Per op: `o_op_start` high the cycle after entering DBL or ADD. With op-unit latency L (finish L cycles after start), each op costs L+1 cycles from entering DBL/ADD to the finish edge.
- `o_finished` is high for exactly one cycle, one cycle after the DONE entry edge. The result is valid in that same cycle and is held afterwards.
- Total ops for k ≥ 2: 2·msb (msb doubles and msb adds).
- k = 0 / infinite P: `o_finished` two cycles after start, with zero ops.

## Test plan
- k=0, P=(5,1) → no `o_op_start`; `o_finished` 2 cycles after start; result (all-ones, all-ones).
- k=1, WIDTH=8 → 8 SCAN cycles, no ops; result = P.
- k=5, mock op unit with L=3 that returns tagged values → exact op sequence DBL, ADD(add=0), DBL, ADD(add=1); operands stable across each op; result = last mock output.
- k=2, P=(5,1) on y²=x³+2x+2 mod 17 with real point_add/double units → result (6,3).
- Reset asserted during DBL_WAIT → all outputs 0 immediately. A subsequent start with k=1 completes normally.
- `i_start` pulsed while busy, and a spurious `i_op_finish` in the ADD state → both ignored; op count and result unchanged.
